// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and queue entry type for the instruction fetch stage.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: imem request/response, execute redirect and decoder handshake.
interface fetch_unit_if;
   import fetch_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [ILEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            fetch_err;

   modport master (
      output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_err,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_err,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc, instr_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with fall-through head, flush and occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      // A pop frees the slot the same cycle, so a push into a full FIFO is fine then.
      do_push  = push && (!full || do_pop);
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order instruction queue, redirect flush.
// Define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect targets via the sticky fetch_err.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic             fetch_err_q, fetch_err_d;

   logic             req_valid, req_fire, rsp_keep, instr_pop;
   fetch_entry_t     q_head, q_push_data, pcf_head, pcf_push_data;
   logic [CNT_W-1:0] q_count, pcf_count;
   logic             q_full, q_empty, pcf_full, pcf_empty;
   logic             unused_fifo_bits;

   always_comb begin
      // Buffered plus in-flight words never exceed DEPTH, so the queue cannot overflow.
      req_valid = !rst && !bus.redirect_valid && !fetch_err_q &&
                  ((32'(outstanding_q) + 32'(q_count)) < 32'(DEPTH));
      req_fire  = req_valid && bus.imem_req_ready;
      rsp_keep  = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;
      instr_pop = !q_empty && bus.instr_ready && !bus.redirect_valid;

      pcf_push_data = '{instr: '0, pc: pc_q};
      q_push_data   = '{instr: bus.imem_rsp_data, pc: pcf_head.pc};

      pc_d          = pc_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
      discard_d     = discard_q;
      fetch_err_d   = fetch_err_q;

      if (bus.redirect_valid) begin
         discard_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHECK_EN
         pc_d        = bus.redirect_pc;
         fetch_err_d = fetch_err_q | (bus.redirect_pc[1:0] != 2'b00);
`else
         pc_d        = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif
      end else begin
         if (req_fire) begin
            pc_d = pc_q + PC_STEP;
         end
         if (bus.imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         fetch_err_q   <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_pc_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .push_data (pcf_push_data),
      .pop       (rsp_keep),
      .flush     (bus.redirect_valid),
      .head      (pcf_head),
      .count     (pcf_count),
      .full      (pcf_full),
      .empty     (pcf_empty)
   );

   fetch_fifo #(.DEPTH(DEPTH)) u_instr_q (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_keep),
      .push_data (q_push_data),
      .pop       (instr_pop),
      .flush     (bus.redirect_valid),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign unused_fifo_bits = ^{pcf_head.instr, pcf_count, pcf_full, pcf_empty, q_full};

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = pc_q;
   assign bus.instr_valid    = !q_empty;
   assign bus.instr          = q_empty ? '0 : q_head.instr;
   assign bus.instr_pc       = q_empty ? '0 : q_head.pc;
   assign bus.fetch_err      = fetch_err_q;

endmodule
